// File: rtl/sevenseg_scan_mux.sv
// Scan controller for a multi-digit common-bus seven-segment display.
// Accepts a display word over valid/ready and time-multiplexes it, one digit per slot.
module sevenseg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int DIGIT_TICKS = 4,
  parameter int DEAD_TICKS  = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  lz_blank,
  input  logic [4*DIGITS-1:0]   s_data,
  input  logic [DIGITS-1:0]     s_dots,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [3:0]            dig_nibble,
  output logic                  dig_dot,
  output logic [DIGITS-1:0]     dig_an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]       ON_LAST   = 8'(DIGIT_TICKS);
  localparam logic [7:0]       DEAD_LAST = 8'(DEAD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic en_meta_q, en_s_q;

  logic [DIGITS-1:0][3:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]      pend_dots_q, pend_dots_d;
  logic                   pend_full_q, pend_full_d;
  logic [DIGITS-1:0][3:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]      disp_dots_q, disp_dots_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       cnt_inc;
  logic             digit_done;
  logic             frame_end;
  logic             load;

  logic [DIGITS-1:0] supp;
  logic              zero_run;

  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nib_q, nib_d;
  logic              dot_q, dot_d;
  logic              frame_done_q, frame_done_d;

  // en is asynchronous to aclk; two flops before anything looks at it
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
    end else begin
      en_meta_q <= en;
      en_s_q    <= en_meta_q;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 8'd1;
    digit_done = 1'b0;
    frame_end  = 1'b0;
    if (!en_s_q) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ON;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_ON: begin
          if (tick) begin
            if (cnt_inc == ON_LAST) begin
              cnt_d = '0;
              if (DEAD_TICKS == 0) begin
                digit_done = 1'b1;
              end else begin
                state_d = S_DEAD;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_DEAD: begin
          if (tick) begin
            if (cnt_inc == DEAD_LAST) begin
              cnt_d      = '0;
              digit_done = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
      if (digit_done) begin
        state_d = S_ON;
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          frame_end = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  // Load and accept are mutually exclusive: load needs a full pending register, accept an empty one
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dots_d = pend_dots_q;
    pend_full_d = pend_full_q;
    disp_data_d = disp_data_q;
    disp_dots_d = disp_dots_q;
    load        = pend_full_q && ((state_q == S_IDLE) || frame_end);
    if (load) begin
      disp_data_d = pend_data_q;
      disp_dots_d = pend_dots_q;
      pend_full_d = 1'b0;
    end
    if (s_valid && !pend_full_q) begin
      pend_data_d = s_data;
      pend_dots_d = s_dots;
      pend_full_d = 1'b1;
    end
  end

  // A digit is blanked when it and every digit to its left are zero with no dot
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (disp_data_d[i] == 4'h0) && !disp_dots_d[i];
      supp[i]  = lz_blank && zero_run;
    end
  end

  // Outputs are registered from next-state values so they line up with the state change
  always_comb begin
    an_d         = '0;
    nib_d        = nib_q;
    dot_d        = dot_q;
    frame_done_d = frame_end;
    if (state_d == S_ON) begin
      nib_d = disp_data_d[idx_d];
      dot_d = disp_dots_d[idx_d];
      if (!supp[idx_d]) begin
        an_d[idx_d] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pend_data_q  <= '0;
      pend_dots_q  <= '0;
      pend_full_q  <= 1'b0;
      disp_data_q  <= '0;
      disp_dots_q  <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      an_q         <= '0;
      nib_q        <= '0;
      dot_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pend_data_q  <= pend_data_d;
      pend_dots_q  <= pend_dots_d;
      pend_full_q  <= pend_full_d;
      disp_data_q  <= disp_data_d;
      disp_dots_q  <= disp_dots_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      nib_q        <= nib_d;
      dot_q        <= dot_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = ~pend_full_q;
  assign dig_an     = an_q;
  assign dig_nibble = nib_q;
  assign dig_dot    = dot_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Bench for sevenseg_scan_mux: lit-slot scoreboard against a frame-level display model,
// plus a second instance without dead time checked against a closed-form timeline.
module tb_sevenseg_scan_mux;
  localparam int D          = 4;
  localparam int DT         = 2;
  localparam int DK         = 1;
  localparam int TP         = 10;
  localparam int SLOT       = DT * TP;
  localparam int FRAME_CYC  = D * (DT + DK) * TP;
  localparam int FRAME0_CYC = D * DT * TP;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        tick = 1'b0;
  logic        en = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] s_data = '0;
  logic [3:0]  s_dots = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  dig_nibble;
  logic        dig_dot;
  logic [3:0]  dig_an;
  logic        frame_done;

  logic        en0 = 1'b0;
  logic        lz0 = 1'b0;
  logic [15:0] s_data0 = '0;
  logic [3:0]  s_dots0 = '0;
  logic        s_valid0 = 1'b0;
  logic        s_ready0;
  logic [3:0]  dig_nibble0;
  logic        dig_dot0;
  logic [3:0]  dig_an0;
  logic        frame_done0;

  sevenseg_scan_mux #(.DIGITS(D), .DIGIT_TICKS(DT), .DEAD_TICKS(DK)) dut (
    .aclk(aclk), .areset(areset), .tick(tick), .en(en), .lz_blank(lz_blank),
    .s_data(s_data), .s_dots(s_dots), .s_valid(s_valid), .s_ready(s_ready),
    .dig_nibble(dig_nibble), .dig_dot(dig_dot), .dig_an(dig_an), .frame_done(frame_done)
  );

  sevenseg_scan_mux #(.DIGITS(D), .DIGIT_TICKS(DT), .DEAD_TICKS(0)) dut0 (
    .aclk(aclk), .areset(areset), .tick(tick), .en(en0), .lz_blank(lz0),
    .s_data(s_data0), .s_dots(s_dots0), .s_valid(s_valid0), .s_ready(s_ready0),
    .dig_nibble(dig_nibble0), .dig_dot(dig_dot0), .dig_an(dig_an0), .frame_done(frame_done0)
  );

  always #25 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // tick is sampled high at every posedge whose index is a multiple of TP
  initial begin
    forever begin
      @(negedge aclk);
      tick = ((cyc + 1) % TP == 0);
    end
  end

  initial begin
    #(60000 * 50);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  typedef struct packed {
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        dot;
    logic [15:0] len;
  } run_t;

  run_t exp_q[$];
  logic chk_en = 1'b0;

  // Display model: what is shown, what waits, and whether leading zeros are blanked
  logic [15:0] m_data = '0;
  logic [3:0]  m_dots = '0;
  logic        m_pfull = 1'b0;
  logic [15:0] m_pdata = '0;
  logic [3:0]  m_pdots = '0;
  logic        m_lz = 1'b0;

  task automatic push_frame();
    run_t r;
    bit all0;
    for (int i = 0; i < D; i++) begin
      all0 = 1'b1;
      for (int j = i; j < D; j++) begin
        if (m_data[4*j +: 4] != 4'h0 || m_dots[j]) all0 = 1'b0;
      end
      if (!(m_lz && i >= 1 && all0)) begin
        r.an  = 4'(1 << i);
        r.nib = m_data[4*i +: 4];
        r.dot = m_dots[i];
        r.len = 16'(SLOT);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic model_frame_end();
    if (m_pfull) begin
      m_data  = m_pdata;
      m_dots  = m_pdots;
      m_pfull = 1'b0;
    end
  endtask

  // Monitor: every completed lit run is popped against the scoreboard; frame spacing is timed
  logic [3:0] prev_an = '0;
  int         run_len = 0;
  logic [3:0] run_nib = '0;
  logic       run_dot = 1'b0;
  int         fstart = -1;
  run_t       got_r, exp_r;

  always @(negedge aclk) begin
    if (!chk_en) fstart = -1;
    if (chk_en && frame_done) begin
      if (fstart >= 0) chk("frame_len", 32'(cyc - fstart), 32'(FRAME_CYC));
      fstart = cyc;
    end
    if (dig_an != prev_an) begin
      if (prev_an != 4'b0 && chk_en) begin
        got_r = {prev_an, run_nib, run_dot, 16'(run_len)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL run_unexpected: got an=%b nib=%h dot=%b len=%0d with nothing expected",
                   got_r.an, got_r.nib, got_r.dot, got_r.len);
        end else begin
          exp_r = exp_q.pop_front();
          if (got_r !== exp_r) begin
            errors++;
            $display("FAIL run: got an=%b nib=%h dot=%b len=%0d expected an=%b nib=%h dot=%b len=%0d",
                     got_r.an, got_r.nib, got_r.dot, got_r.len,
                     exp_r.an, exp_r.nib, exp_r.dot, exp_r.len);
          end
        end
      end
      if (dig_an != 4'b0) begin
        run_len = 1;
        run_nib = dig_nibble;
        run_dot = dig_dot;
        if (chk_en && fstart < 0 && dig_an == 4'b0001) fstart = cyc;
      end
    end else if (dig_an != 4'b0) begin
      run_len++;
    end
    prev_an = dig_an;
  end

  task automatic wait_negs(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic offer_idle(input logic [15:0] d, input logic [3:0] dt);
    int g;
    @(negedge aclk);
    s_data  = d;
    s_dots  = dt;
    s_valid = 1'b1;
    g = 0;
    while (!s_ready && g < 100) begin
      @(negedge aclk);
      g++;
    end
    if (!s_ready) begin
      fail_timeout("idle_accept");
      s_valid = 1'b0;
    end else begin
      @(negedge aclk);
      s_valid = 1'b0;
      chk("ready_low_after_accept", 32'(s_ready), 32'd0);
      @(negedge aclk);
      chk("ready_after_idle_load", 32'(s_ready), 32'd1);
      m_data = d;
      m_dots = dt;
    end
  endtask

  // Raise en so the scan starts right on a tick boundary and the first slot is full length
  task automatic enable_aligned();
    chk_en = 1'b1;
    push_frame();
    do @(negedge aclk); while ((cyc + 3) % TP != 0);
    en = 1'b1;
  endtask

  task automatic wait_frame(input bit push_next);
    int g;
    g = 0;
    do begin
      @(negedge aclk);
      g++;
    end while (!frame_done && g < 2 * FRAME_CYC);
    if (!frame_done) begin
      fail_timeout("frame_done");
    end else begin
      model_frame_end();
      if (push_next) push_frame();
    end
  endtask

  task automatic end_phase();
    @(posedge aclk);
    chk_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge aclk);
    en = 1'b0;
    wait_negs(5);
    exp_q.delete();
  endtask

  task automatic run_word(input logic [15:0] d, input logic [3:0] dt, input logic lz, input int nframes);
    lz_blank = lz;
    m_lz     = lz;
    offer_idle(d, dt);
    enable_aligned();
    for (int f = 0; f < nframes - 1; f++) wait_frame(1'b1);
    wait_frame(1'b0);
    end_phase();
  endtask

  task automatic back_pressure();
    int g;
    int leak;
    lz_blank = 1'b0;
    m_lz     = 1'b0;
    offer_idle(16'h3C5E, 4'b0001);
    enable_aligned();
    wait_frame(1'b1);
    wait_negs(35);
    s_data  = 16'hA9B8;
    s_dots  = 4'b1000;
    s_valid = 1'b1;
    chk("bp_ready_before_A", 32'(s_ready), 32'd1);
    @(negedge aclk);
    m_pfull = 1'b1;
    m_pdata = 16'hA9B8;
    m_pdots = 4'b1000;
    s_data  = 16'h6017;
    s_dots  = 4'b0110;
    chk("bp_ready_after_A", 32'(s_ready), 32'd0);
    leak = 0;
    g = 0;
    do begin
      @(negedge aclk);
      g++;
      if (!frame_done && s_ready) leak++;
    end while (!frame_done && g < 2 * FRAME_CYC);
    chk("bp_ready_held", 32'(leak), 32'd0);
    if (!frame_done) begin
      fail_timeout("bp_frame_done");
      s_valid = 1'b0;
    end else begin
      model_frame_end();
      push_frame();
      chk("bp_ready_after_load", 32'(s_ready), 32'd1);
      @(negedge aclk);
      s_valid = 1'b0;
      chk("bp_B_accepted", 32'(s_ready), 32'd0);
      m_pfull = 1'b1;
      m_pdata = 16'h6017;
      m_pdots = 4'b0110;
      wait_frame(1'b1);
      wait_frame(1'b0);
    end
    end_phase();
  endtask

  task automatic enable_drop();
    int g;
    lz_blank = 1'b0;
    m_lz     = 1'b0;
    offer_idle(16'h8642, 4'b0101);
    enable_aligned();
    g = 0;
    do begin
      @(negedge aclk);
      g++;
    end while (dig_an != 4'b0100 && g < FRAME_CYC);
    if (dig_an != 4'b0100) fail_timeout("endrop_digit2");
    chk_en = 1'b0;
    wait_negs(5);
    en = 1'b0;
    wait_negs(2);
    chk("endrop_still_lit", 32'(dig_an), 32'b0100);
    @(negedge aclk);
    chk("endrop_dark", 32'(dig_an), 32'd0);
    chk("endrop_unfinished_slots", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    wait_negs(4);
    enable_aligned();
    wait_frame(1'b0);
    end_phase();
  endtask

  task automatic reset_mid();
    lz_blank = 1'b0;
    m_lz     = 1'b0;
    offer_idle(16'h9BCD, 4'b1111);
    enable_aligned();
    wait_negs(36);
    chk_en  = 1'b0;
    s_data  = 16'h5555;
    s_dots  = 4'b0000;
    s_valid = 1'b1;
    @(negedge aclk);
    s_valid = 1'b0;
    chk("rst_pending_full", 32'(s_ready), 32'd0);
    chk("rst_prelit", 32'({dig_an, dig_nibble, dig_dot}), 32'({4'b0010, 4'hC, 1'b1}));
    #2;
    areset = 1'b1;
    en     = 1'b0;
    #1;
    chk("rst_async_an", 32'(dig_an), 32'd0);
    chk("rst_async_nibble", 32'(dig_nibble), 32'd0);
    chk("rst_async_dot", 32'(dig_dot), 32'd0);
    chk("rst_async_ready", 32'(s_ready), 32'd1);
    chk("rst_async_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    m_data  = '0;
    m_dots  = '0;
    m_pfull = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    wait_negs(2);
    enable_aligned();
    wait_frame(1'b1);
    wait_frame(1'b0);
    end_phase();
  endtask

  // Without dead time the anode steps straight from one digit to the next
  task automatic no_dead();
    logic [15:0] w;
    logic [3:0]  wd;
    int          k;
    logic [3:0]  e_an;
    logic        e_fd;
    w  = 16'h4321;
    wd = 4'b1001;
    @(negedge aclk);
    chk("nd_ready", 32'(s_ready0), 32'd1);
    s_data0  = w;
    s_dots0  = wd;
    s_valid0 = 1'b1;
    @(negedge aclk);
    s_valid0 = 1'b0;
    wait_negs(3);
    do @(negedge aclk); while ((cyc + 3) % TP != 0);
    en0 = 1'b1;
    wait_negs(3);
    for (int t = 0; t < 2 * FRAME0_CYC; t++) begin
      k    = (t / SLOT) % D;
      e_an = 4'(1 << k);
      e_fd = (t > 0) && (t % FRAME0_CYC == 0);
      chk("nd_timeline", 32'({dig_an0, dig_nibble0, dig_dot0, frame_done0}),
          32'({e_an, w[4*k +: 4], wd[k], e_fd}));
      @(negedge aclk);
    end
    en0 = 1'b0;
    wait_negs(5);
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rdt;
    int          nz;
    #3;
    areset = 1'b1;
    wait_negs(3);
    chk("reset_an", 32'(dig_an), 32'd0);
    chk("reset_nibble", 32'(dig_nibble), 32'd0);
    chk("reset_dot", 32'(dig_dot), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_ready", 32'(s_ready), 32'd1);
    chk("reset_an_nodead", 32'(dig_an0), 32'd0);
    areset = 1'b0;
    wait_negs(2);

    run_word(16'h12A4, 4'b0010, 1'b0, 2);
    run_word(16'h0050, 4'b0000, 1'b1, 2);
    run_word(16'h0003, 4'b0100, 1'b1, 1);
    run_word(16'h0000, 4'b0000, 1'b1, 1);
    run_word(16'h0050, 4'b0000, 1'b0, 1);

    for (int n = 0; n < 6; n++) begin
      rd  = 16'($urandom);
      rdt = 4'($urandom);
      nz  = $urandom_range(0, 3);
      for (int j = 0; j < nz; j++) begin
        rd[4*(D-1-j) +: 4] = 4'h0;
        if ($urandom_range(0, 3) != 0) rdt[D-1-j] = 1'b0;
      end
      run_word(rd, rdt, 1'($urandom_range(0, 1)), 1);
    end

    back_pressure();
    enable_drop();
    reset_mid();
    no_dead();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_mux.md
# sevenseg_scan_mux

Time-multiplexing scan controller for a multi-digit common-bus seven-segment display. It sits directly upstream of `driver_sevenseg_dot`. It accepts a whole display word (one nibble plus one dot flag per digit) over a valid/ready handshake. It then steps through the digits on the shared `tick` timebase, presenting one digit's nibble and dot to the segment driver while asserting that digit's anode. A blanking (dead) interval between digits suppresses ghosting, and display updates happen only at frame boundaries, so a frame never tears.

## Interface
- `DIGITS`, default 4: number of digits; legal range 2..8.
- `DIGIT_TICKS`, default 4: ticks each digit stays lit; legal range 1..255.
- `DEAD_TICKS`, default 1: blank ticks after each digit; legal range 0..15, where 0 means no dead interval.

- `aclk`, in, 1: clock, 20 MHz; all logic on the rising edge.
- `areset`, in, 1: reset, asynchronous, active-high.
- `tick`, in, 1: one-cycle timebase strobe, synchronous to `aclk`.
- `en`, in, 1: scan enable; asynchronous; active-high.
- `lz_blank`, in, 1: leading-zero suppression enable; synchronous.
- `s_data`, in, 4*DIGITS: display word; digit i is `s_data[4i+3:4i]`, and digit 0 is rightmost.
- `s_dots`, in, DIGITS: dot flag per digit.
- `s_valid`, in, 1: the word on `s_data`/`s_dots` is offered.
- `s_ready`, out, 1: the pending register is empty.
- `dig_nibble`, out, 4: nibble for the segment driver `data[3:0]`.
- `dig_dot`, out, 1: dot for the segment driver.
- `dig_an`, out, DIGITS: one-hot anode select, active-high; all zeros when nothing is lit.
- `frame_done`, out, 1: one-cycle pulse at the end of each full scan.

## Operation
- **Registers:**
  - pending (word, dots, full flag);
  - display (word, dots);
  - digit index `idx`;
  - tick counter, 8 bits;
  - FSM.
- **`en` synchronisation:** `en` passes through a 2-FF synchronizer; `en_s` is the synchronized copy.
- **Handshake:**
  - Transfer occurs when `s_valid && s_ready`.
  - `s_ready` = NOT pending-full.
  - An accepted word sets pending-full.
  - While pending is full, `s_ready` stays low and new offers are held off.
- **Pending → display load:**
  - In the FSM_IDLE state, the load happens on the next cycle.
  - Otherwise the load happens only in the frame-end cycle.
  - The load clears pending-full, so `s_ready` rises the cycle after the load.
  - The load uses the pending contents as of the frame-end cycle. A word accepted in that same cycle waits for the next frame; there is no bypass.
- **FSM states:** IDLE, ON, DEAD.
  - IDLE → ON when `en_s` = 1; `idx` = 0, counter = 0.
  - ON, on a tick: the counter increments. When it reaches `DIGIT_TICKS`, the counter clears and the FSM moves to DEAD. If `DEAD_TICKS` = 0, the FSM instead takes the DEAD-exit action directly.
  - DEAD, on a tick: the counter increments. When it reaches `DEAD_TICKS`, the exit action runs:
    - if `idx` = DIGITS-1: `idx` returns to 0, `frame_done` pulses, the pending load is applied, and the FSM goes to ON;
    - otherwise `idx` increments and the FSM goes to ON.
  - Any state → IDLE when `en_s` = 0. In IDLE the counter and `idx` are 0 and `dig_an` is 0.
- **Outputs in ON:**
  - `dig_nibble` = display nibble[`idx`];
  - `dig_dot` = display dot[`idx`];
  - `dig_an` = one-hot(`idx`), unless that digit is suppressed.
- **Outputs in DEAD and IDLE:** `dig_an` = 0; `dig_nibble` and `dig_dot` hold their last values.
- **Leading-zero suppression:** when `lz_blank` = 1, digit i (i ≥ 1) is suppressed if every digit j ≥ i has nibble 0 and dot 0. Digit 0 is never suppressed. A suppressed digit still occupies its full ON and DEAD time with `dig_an` = 0, so scan timing is unchanged.
- **`tick` while not running:** a `tick` arriving while the FSM is in IDLE is ignored.

## Timing
- All outputs are registered.
- The state change caused by a `tick` in cycle N is visible at outputs in cycle N+1.
- `frame_done` is high in cycle N+1 only.
- `en` latency: an edge on `en` affects `dig_an` 3 cycles later (2 sync stages plus the output register).
- **Frame length:** DIGITS × (DIGIT_TICKS + DEAD_TICKS) ticks.
- **Reset values:**
  - `dig_an` = 0, `dig_nibble` = 0, `dig_dot` = 0, `frame_done` = 0;
  - `s_ready` = 1;
  - pending and display registers = 0;
  - `idx` = 0; FSM = IDLE.
- **Reset mid-operation:** `areset` forces all reset values immediately, without waiting for a clock edge. Any pending word is discarded.

## Test plan
Unless a scenario states otherwise, the configuration is DIGITS=4, DIGIT_TICKS=2, DEAD_TICKS=1, with a tick every 10 cycles.

- **Reset:** assert `areset` mid-scan → `dig_an`, `dig_nibble`, `dig_dot` = 0 immediately; `s_ready` = 1; after release the display shows "0000" once enabled.
- **Basic scan:** with `en` = 0, load `s_data` = 16'h12A4 and `s_dots` = 4'b0010, then raise `en`. Required response:
  - `dig_an` sequence 0001 (nibble 4, 2 ticks) → 0000 (1 tick) → 0010 (nibble A, dot 1) → 0000 → 0100 (nibble 2) → 0000 → 1000 (nibble 1) → 0000;
  - `frame_done` pulses after 12 ticks.
- **Leading zeros:** `lz_blank` = 1, data 16'h0050 → digits 3 and 2 have `dig_an` = 0 during their slots; digits 1 (nibble 5) and 0 (nibble 0) are lit; frame still 12 ticks.
- **Back-pressure:** accept word A mid-frame → `s_ready` = 0, and word B is held with `s_valid` = 1. Required response:
  - the display switches to A only on the cycle after `frame_done`;
  - B is accepted the following cycle.
- **Enable drop:** `en` = 0 during digit 2 ON → `dig_an` = 0 within 3 cycles. On re-enable, the scan restarts at digit 0 with a full 2-tick slot.
- **No dead time:** DEAD_TICKS = 0 → `dig_an` steps 0001 → 0010 directly, with no zero gap; frame is 8 ticks.
